regfile_scoreboard: RTL and testbench

Integer register file with a pending-write scoreboard. It is the receiving end of the writeback port (`wbEn`/`wd`/`wbData`): it stores the results, supplies two bypassed read ports to decode, and tracks in-flight destinations so decode can stall on RAW hazards. It sits between the decode stage (reads, issue) and the writeback stage (writes, redirect flush).

---
 rtl/regfile_scoreboard_pkg.sv | 9 +
 rtl/reg_scoreboard.sv | 67 ++++++
 rtl/regfile_scoreboard.sv | 61 ++++++
 tb/tb_regfile_scoreboard.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and sizing constants for the integer register file and its
// pending-write scoreboard.
package regfile_scoreboard_pkg;
  typedef logic [4:0]  u5;
  typedef logic [63:0] u64;

  localparam int NREG     = 32;
  localparam int SB_CNT_W = 2;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with issue/writeback/flush updates.
// Produces the RAW-hazard stall (srcBusy) and the issue throttle (issueReady).
module reg_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREG  = regfile_scoreboard_pkg::NREG,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic wbEn,
  input  u5    wd,
  input  u5    ra1,
  input  u5    ra2,
  input  logic issueEn,
  input  u5    issueRd,
  input  logic flush,
  input  logic flushKeepEn,
  input  u5    flushKeepRd,
  output logic srcBusy,
  output logic issueReady
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  inc_hit;
  logic [NREG-1:0]  dec_hit;
  logic [CNT_W-1:0] wb_hit1;
  logic [CNT_W-1:0] wb_hit2;

  // A writeback landing this cycle is covered by the bypass, so it discounts one pending write.
  always_comb begin
    issueReady = (cnt_q[issueRd] != CNT_MAX);
    wb_hit1    = CNT_W'(wbEn && (wd == ra1));
    wb_hit2    = CNT_W'(wbEn && (wd == ra2));
    srcBusy    = ((ra1 != '0) && (cnt_q[ra1] > wb_hit1)) ||
                 ((ra2 != '0) && (cnt_q[ra2] > wb_hit2));
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc_hit[r] = issueEn && issueReady && !flush && (issueRd == u5'(r));
      dec_hit[r] = wbEn && (wd == u5'(r));
      cnt_d[r]   = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (flush) begin
        cnt_d[r] = (flushKeepEn && (flushKeepRd == u5'(r)) && !dec_hit[r]) ? CNT_W'(1) : '0;
      end else if (inc_hit[r] && !dec_hit[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec_hit[r] && !inc_hit[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass on both read ports; the
// scoreboard tracks in-flight destinations so decode can stall on RAW hazards.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int NREG  = regfile_scoreboard_pkg::NREG,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic wbEn,
  input  u5    wd,
  input  u64   wbData,
  input  u5    ra1,
  input  u5    ra2,
  output u64   rd1,
  output u64   rd2,
  output logic srcBusy,
  input  logic issueEn,
  input  u5    issueRd,
  output logic issueReady,
  input  logic flush,
  input  logic flushKeepEn,
  input  u5    flushKeepRd
);

  u64 regs_q [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (wbEn && (wd != '0)) begin
      regs_q[wd] <= wbData;
    end
  end

  always_comb begin
    rd1 = (ra1 == '0) ? '0 : (wbEn && (wd == ra1)) ? wbData : regs_q[ra1];
    rd2 = (ra2 == '0) ? '0 : (wbEn && (wd == ra2)) ? wbData : regs_q[ra2];
  end

  reg_scoreboard #(
    .NREG (NREG),
    .CNT_W(CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wbEn       (wbEn),
    .wd         (wd),
    .ra1        (ra1),
    .ra2        (ra2),
    .issueEn    (issueEn),
    .issueRd    (issueRd),
    .flush      (flush),
    .flushKeepEn(flushKeepEn),
    .flushKeepRd(flushKeepRd),
    .srcBusy    (srcBusy),
    .issueReady (issueReady)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized bench for regfile_scoreboard against a count-per-register reference model.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic        wbEn;
  logic [4:0]  wd;
  logic [63:0] wbData;
  logic [4:0]  ra1, ra2;
  logic [63:0] rd1, rd2;
  logic        srcBusy;
  logic        issueEn;
  logic [4:0]  issueRd;
  logic        issueReady;
  logic        flush, flushKeepEn;
  logic [4:0]  flushKeepRd;

  int errs   = 0;
  int checks = 0;

  int          m_cnt  [32];
  logic [63:0] m_regs [32];

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .wbEn(wbEn), .wd(wd), .wbData(wbData),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .srcBusy(srcBusy),
    .issueEn(issueEn), .issueRd(issueRd), .issueReady(issueReady),
    .flush(flush), .flushKeepEn(flushKeepEn), .flushKeepRd(flushKeepRd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_rd(input logic [4:0] ra);
    if (ra == 0) return 64'd0;
    if (wbEn && wd == ra) return wbData;
    return m_regs[ra];
  endfunction

  function automatic logic m_busy_one(input logic [4:0] ra);
    int landing;
    landing = (wbEn && wd == ra) ? 1 : 0;
    return (ra != 0) && (m_cnt[ra] - landing > 0);
  endfunction

  function automatic logic m_ready();
    return m_cnt[issueRd] < 3;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) begin
      m_cnt[r]  = 0;
      m_regs[r] = 64'd0;
    end
  endtask

  task automatic idle();
    wbEn = 0; wd = 0; wbData = 0; ra1 = 0; ra2 = 0;
    issueEn = 0; issueRd = 0; flush = 0; flushKeepEn = 0; flushKeepRd = 0;
  endtask

  // Compare every output against the model, then advance one clock and update the model.
  task automatic cyc();
    logic rdy;
    #1;
    check("rd1", rd1, m_rd(ra1));
    check("rd2", rd2, m_rd(ra2));
    check("srcBusy", {63'd0, srcBusy}, {63'd0, m_busy_one(ra1) | m_busy_one(ra2)});
    check("issueReady", {63'd0, issueReady}, {63'd0, m_ready()});
    rdy = m_ready();
    @(posedge clk);
    if (flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      if (flushKeepEn && flushKeepRd != 0)
        m_cnt[flushKeepRd] = (wbEn && wd == flushKeepRd) ? 0 : 1;
    end else begin
      if (issueEn && rdy && issueRd != 0 && !(wbEn && wd == issueRd))
        m_cnt[issueRd] = m_cnt[issueRd] + 1;
      if (wbEn && wd != 0 && !(issueEn && rdy && issueRd == wd) && m_cnt[wd] > 0)
        m_cnt[wd] = m_cnt[wd] - 1;
    end
    if (wbEn && wd != 0) m_regs[wd] = wbData;
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] r);
    idle(); issueEn = 1; issueRd = r; cyc();
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    idle(); wbEn = 1; wd = r; wbData = d; cyc();
  endtask

  initial begin
    idle();
    m_clear();
    rst = 0;
    #12;
    ra1 = 5'd3; issueRd = 5'd3;
    #1;
    check("reset_rd1", rd1, 64'd0);
    check("reset_busy", {63'd0, srcBusy}, 64'd0);
    check("reset_ready", {63'd0, issueReady}, 64'd1);
    @(negedge clk);
    rst = 1;

    // x0 is never written and always reads zero
    idle(); wbEn = 1; wd = 0; wbData = 64'd5; cyc();
    idle(); ra1 = 0; #1;
    check("x0_rd1", rd1, 64'd0);
    check("x0_busy", {63'd0, srcBusy}, 64'd0);
    check("x0_ready", {63'd0, issueReady}, 64'd1);
    cyc();

    idle(); wbEn = 1; wd = 7; wbData = 64'hDEAD_BEEF; ra1 = 7; #1;
    check("bypass_rd1", rd1, 64'hDEAD_BEEF);
    cyc();
    idle(); ra1 = 7; #1;
    check("array_rd1", rd1, 64'hDEAD_BEEF);
    cyc();

    issue(5'd3);
    idle(); ra2 = 3;
    repeat (3) begin
      #1; check("raw_busy", {63'd0, srcBusy}, 64'd1);
      cyc();
    end
    idle(); ra2 = 3; wbEn = 1; wd = 3; wbData = 64'd42; #1;
    check("raw_wb_busy", {63'd0, srcBusy}, 64'd0);
    check("raw_wb_rd2", rd2, 64'd42);
    cyc();

    repeat (3) issue(5'd5);
    idle(); issueEn = 1; issueRd = 5; #1;
    check("sat_ready", {63'd0, issueReady}, 64'd0);
    cyc();
    wb(5'd5, 64'd50);
    idle(); ra1 = 5; issueRd = 5; #1;
    check("sat_after1_busy", {63'd0, srcBusy}, 64'd1);
    check("sat_after1_ready", {63'd0, issueReady}, 64'd1);
    cyc();
    wb(5'd5, 64'd51);
    wb(5'd5, 64'd52);
    idle(); ra1 = 5; #1;
    check("sat_drained_busy", {63'd0, srcBusy}, 64'd0);
    cyc();

    issue(5'd9);
    idle(); issueEn = 1; issueRd = 9; wbEn = 1; wd = 9; wbData = 64'd99; cyc();
    idle(); ra1 = 9; #1;
    check("same_cycle_busy", {63'd0, srcBusy}, 64'd1);
    cyc();
    wb(5'd9, 64'd100);

    issue(5'd4); issue(5'd4); issue(5'd6);
    idle(); flush = 1; flushKeepEn = 1; flushKeepRd = 6; issueEn = 1; issueRd = 4; ra1 = 4; #1;
    check("flush_cycle_busy", {63'd0, srcBusy}, 64'd1);
    cyc();
    idle(); ra1 = 4; #1;
    check("flush_x4_busy", {63'd0, srcBusy}, 64'd0);
    cyc();
    idle(); ra1 = 6; #1;
    check("flush_x6_busy", {63'd0, srcBusy}, 64'd1);
    cyc();

    // asynchronous reset with x2 and x6 still pending
    issue(5'd2);
    idle(); ra1 = 6; ra2 = 2; rst = 0; #1;
    check("midrst_busy", {63'd0, srcBusy}, 64'd0);
    check("midrst_rd2", rd2, 64'd0);
    m_clear();
    #1 rst = 1;
    cyc();

    for (int i = 0; i < 3000; i++) begin
      idle();
      ra1         = 5'($urandom_range(0, 7));
      ra2         = 5'($urandom_range(0, 7));
      issueEn     = ($urandom_range(0, 1) == 1);
      issueRd     = 5'($urandom_range(0, 7));
      wbEn        = ($urandom_range(0, 9) < 4);
      wd          = 5'($urandom_range(0, 7));
      wbData      = {$urandom, $urandom};
      flush       = ($urandom_range(0, 29) == 0);
      flushKeepEn = ($urandom_range(0, 1) == 1);
      flushKeepRd = 5'($urandom_range(0, 7));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
